// File: rtl/cmult_pipe.sv
// Pipelined fixed-point multiplier for real pairs, complex products and products with a conjugate.
// Full-precision combine, then optional rounding, one arithmetic shift and a saturating/wrapping range check.
module cmult_pipe #(
    parameter int W      = 32,
    parameter int SHIFT  = 32,
    parameter int SIGNED = 0,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_mode,
    input  logic [W-1:0]   a_re,
    input  logic [W-1:0]   a_im,
    input  logic [W-1:0]   b_re,
    input  logic [W-1:0]   b_im,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out,
    output logic [1:0]     out_ovf
);

    localparam int PW = 2 * W;
    // Three guard bits keep the add/sub plus rounding constant free of internal overflow.
    localparam int IW = 2 * W + 3;

    localparam logic signed [IW-1:0] RND_K = (ROUND != 0) ? $signed(IW'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [IW-1:0] MAX_V = (SIGNED != 0) ? $signed((IW'(1) << (W - 1)) - IW'(1))
                                                           : $signed((IW'(1) << W) - IW'(1));
    localparam logic signed [IW-1:0] MIN_V = (SIGNED != 0) ? -$signed(IW'(1) << (W - 1)) : '0;

    function automatic logic [PW-1:0] f_ext(input logic [W-1:0] v);
        return {{W{(SIGNED != 0) && v[W-1]}}, v};
    endfunction

    function automatic logic signed [IW-1:0] f_wide(input logic [PW-1:0] p);
        return $signed({{3{(SIGNED != 0) && p[PW-1]}}, p});
    endfunction

    logic w_adv;

    // Operand register in front of the multipliers
    logic           r_v0;
    logic [1:0]     r_mode0;
    logic [W-1:0]   r_a_re, r_a_im, r_b_re, r_b_im;

    // Stage 1: products
    logic           r_v1;
    logic [1:0]     r_mode1;
    logic [PW-1:0]  r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic [PW-1:0]  w_p_rr, w_p_ii, w_p_ri, w_p_ir;

    // Stage 2: combined and scaled
    logic                  r_v2;
    logic signed [IW-1:0]  r_re2, r_im2;
    logic signed [IW-1:0]  w_rr, w_ii, w_ri, w_ir;
    logic signed [IW-1:0]  w_re_full, w_im_full, w_re_sh, w_im_sh;

    // Stage 3: range-checked result
    logic           r_v3;
    logic [PW-1:0]  r_out;
    logic [1:0]     r_ovf;
    logic [PW-1:0]  w_res;
    logic [1:0]     w_ovf_vec;
    logic signed [IW-1:0] w_lane_in [2];

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign out       = r_out;
    assign out_ovf   = r_ovf;

    // Extended operands make the low PW bits of the product exact for either signedness.
    assign w_p_rr = f_ext(r_a_re) * f_ext(r_b_re);
    assign w_p_ii = f_ext(r_a_im) * f_ext(r_b_im);
    assign w_p_ri = f_ext(r_a_re) * f_ext(r_b_im);
    assign w_p_ir = f_ext(r_a_im) * f_ext(r_b_re);

    assign w_rr = f_wide(r_p_rr);
    assign w_ii = f_wide(r_p_ii);
    assign w_ri = f_wide(r_p_ri);
    assign w_ir = f_wide(r_p_ir);

    always_comb begin
        w_re_full = w_rr;
        w_im_full = w_ii;
        case (r_mode1)
            2'd1: begin
                w_re_full = w_rr - w_ii;
                w_im_full = w_ri + w_ir;
            end
            2'd2: begin
                w_re_full = w_rr + w_ii;
                w_im_full = w_ir - w_ri;
            end
            default: begin
                w_re_full = w_rr;
                w_im_full = w_ii;
            end
        endcase
    end

    assign w_re_sh = (w_re_full + RND_K) >>> SHIFT;
    assign w_im_sh = (w_im_full + RND_K) >>> SHIFT;

    assign w_lane_in[0] = r_im2;
    assign w_lane_in[1] = r_re2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [W-1:0] w_val;
            logic         w_ovf;

            always_comb begin
                w_val = w_lane_in[gi][W-1:0];
                w_ovf = 1'b0;
                if (w_lane_in[gi] > MAX_V) begin
                    w_ovf = 1'b1;
                    if (SAT != 0) begin
                        w_val = MAX_V[W-1:0];
                    end
                end else if (w_lane_in[gi] < MIN_V) begin
                    w_ovf = 1'b1;
                    if (SAT != 0) begin
                        w_val = MIN_V[W-1:0];
                    end
                end
            end

            assign w_res[gi*W +: W] = w_val;
            assign w_ovf_vec[gi]    = w_ovf;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v0    <= 1'b0;
            r_mode0 <= '0;
            r_a_re  <= '0;
            r_a_im  <= '0;
            r_b_re  <= '0;
            r_b_im  <= '0;
            r_v1    <= 1'b0;
            r_mode1 <= '0;
            r_p_rr  <= '0;
            r_p_ii  <= '0;
            r_p_ri  <= '0;
            r_p_ir  <= '0;
            r_v2    <= 1'b0;
            r_re2   <= '0;
            r_im2   <= '0;
            r_v3    <= 1'b0;
            r_out   <= '0;
            r_ovf   <= '0;
        end else if (w_adv) begin
            r_v0    <= in_valid;
            r_mode0 <= (in_mode == 2'd3) ? 2'd0 : in_mode;
            r_a_re  <= a_re;
            r_a_im  <= a_im;
            r_b_re  <= b_re;
            r_b_im  <= b_im;

            r_v1    <= r_v0;
            r_mode1 <= r_mode0;
            r_p_rr  <= w_p_rr;
            r_p_ii  <= w_p_ii;
            r_p_ri  <= w_p_ri;
            r_p_ir  <= w_p_ir;

            r_v2    <= r_v1;
            r_re2   <= w_re_sh;
            r_im2   <= w_im_sh;

            // Output data only moves for real samples so it holds through bubbles.
            r_v3    <= r_v2;
            if (r_v2) begin
                r_out <= w_res;
                r_ovf <= w_ovf_vec;
            end
        end
    end

endmodule
